fpu_mul_arbiter: RTL
====================

FPU_MUL_ARBITER -- requirements
Module: fpu_mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 Parameter FP_W, default 32, operand/result width (IEEE-754 single).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  requester i has an operation pending.
REQ-006 req_a  input  FP_W*NUM_REQ  operand A, slice i for requester i.
REQ-007 req_b  input  FP_W*NUM_REQ  operand B, slice i for requester i.
REQ-008 req_ready  output  NUM_REQ  one-cycle pulse: requester i's operands accepted.
REQ-009 rsp_valid  output  NUM_REQ  one-hot: result for requester i is on rsp_z.
REQ-010 rsp_z  output  FP_W  product returned to granted requester.
REQ-011 rsp_ready  input  NUM_REQ  requester i consumes result.
REQ-012 mul_a / mul_a_req / mul_a_ack  output FP_W / output 1 / input 1  multiplier operand A handshake.
REQ-013 mul_b / mul_b_req / mul_b_ack  output FP_W / output 1 / input 1  multiplier operand B handshake.
REQ-014 mul_z / mul_z_req / mul_z_ack  input FP_W / input 1 / output 1  multiplier result handshake.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 op_count  output  16  completed operations, wraps.

Function
REQ-017 States SHALL be IDLE, SEND_A, SEND_B, WAIT_Z, RESPOND.
REQ-018 IDLE: if any req_valid, grant the first set bit searching from (last_grant+1) mod NUM_REQ upward; latch index and both operand slices; pulse req_ready[idx]; go SEND_A next cycle.
REQ-019 SEND_A: mul_a holds latched A, mul_a_req=1; on an edge where mul_a_req&&mul_a_ack, clear mul_a_req and go SEND_B.
REQ-020 SEND_B: same rule with mul_b/mul_b_req/mul_b_ack; go WAIT_Z.
REQ-021 WAIT_Z: on first edge with mul_z_req=1, capture mul_z and set registered mul_z_ack=1 for exactly one cycle; go RESPOND; mul_z_ack SHALL be 0 in every other cycle.
REQ-022 RESPOND: rsp_valid[idx]=1, rsp_z=captured result, held until rsp_ready[idx]=1; on that edge clear rsp_valid, set last_grant=idx, increment op_count, go IDLE.
REQ-023 Latency: req_ready pulse at cycle T; mul_a_req visible at T+1; minimum request-to-rsp_valid overhead is 4 cycles plus multiplier compute time.
REQ-024 Only one operation in flight; no new grant before RESPOND completes.
REQ-025 rsp_ready bits of non-granted requesters, and req_valid changes after acceptance, SHALL be ignored.
REQ-026 All requesters continuously valid: grants rotate 0,1,...,NUM_REQ-1,0; each requester served within NUM_REQ operations.
REQ-027 rsp_z SHALL hold the last result after RESPOND; mul_a/mul_b hold last operands.
REQ-028 op_count wraps 16'hFFFF -> 16'h0000.

Reset
REQ-029 On rst: state=IDLE, last_grant=NUM_REQ-1 (first grant goes to requester 0), req_ready=0, rsp_valid=0, rsp_z=0, mul_a=0, mul_b=0, mul_a_req=0, mul_b_req=0, mul_z_ack=0, busy=0, op_count=0.
REQ-030 Reset mid-operation SHALL abandon the operation without a response; multiplier shares clk/rst and resets together.

Structure
REQ-031 Package fpu_arb_pkg SHALL hold the state enumeration, FP_W default and NUM_REQ default.
REQ-032 One sub-module, rr_arbiter (combinational round-robin priority pick from request vector and last_grant), SHALL be instantiated.

Verification
REQ-033 Requester 0: A=0x40000000, B=0x40400000 -> rsp_valid[0], rsp_z=0x40C00000 (2.0*3.0), op_count=1.
REQ-034 Requester 2: A=0x3FC00000, B=0xC0000000 -> rsp_valid[2], rsp_z=0xC0400000; no other rsp_valid bit ever set.
REQ-035 All four req_valid held from reset -> grant order 0,1,2,3,0, one req_ready pulse per grant.
REQ-036 rsp_ready low 10 cycles in RESPOND -> rsp_valid and rsp_z stable, no new grant, mul_a_req stays 0.
REQ-037 rst asserted during WAIT_Z -> next cycle all outputs at reset values; subsequent request completes correctly.
REQ-038 Force op_count to 0xFFFF via 65535 ops or preload -> next completion gives 0x0000.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the floating-point multiplier arbiter: default
// widths, the operation-counter width and the controller state encoding.
package fpu_arb_pkg;

    localparam int FP_W_DEFAULT    = 32;
    localparam int NUM_REQ_DEFAULT = 4;
    localparam int OP_COUNT_W      = 16;

    // One operation walks IDLE -> SEND_A -> SEND_B -> WAIT_Z -> RESPOND -> IDLE.
    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        RESPOND
    } arbState_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: starting just after the last granted
// requester and wrapping around, select the first requester with a request.
// The last-granted requester itself is checked last, so it only wins when
// nobody else is asking.
module rr_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_lastGrant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grantIdx,
    output logic               o_anyReq
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_candIdx;

    // Scan offsets 1..NUM_REQ from the last grant, keeping the first hit.
    always_comb begin
        o_anyReq   = 1'b0;
        o_grantIdx = '0;
        o_grant    = '0;
        w_sum      = '0;
        w_candIdx  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_sum = {1'b0, i_lastGrant} + (IDX_W+1)'(off);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_candIdx = w_sum[IDX_W-1:0];
            if (!o_anyReq && i_req[w_candIdx]) begin
                o_anyReq   = 1'b1;
                o_grantIdx = w_candIdx;
            end
        end
        if (o_anyReq) begin
            o_grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << o_grantIdx;
        end
    end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one handshaked floating-point multiplier among NUM_REQ requesters.
// A round-robin pick accepts one requester's operands, the operands are sent
// to the multiplier one at a time, the product is captured and presented to
// the granted requester until it consumes it. Only one operation is in
// flight at a time.
module fpu_mul_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int FP_W    = FP_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [FP_W*NUM_REQ-1:0] req_a,
    input  logic [FP_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]         rsp_z,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]         mul_a,
    output logic                    mul_a_req,
    input  logic                    mul_a_ack,
    output logic [FP_W-1:0]         mul_b,
    output logic                    mul_b_req,
    input  logic                    mul_b_ack,
    input  logic [FP_W-1:0]         mul_z,
    input  logic                    mul_z_req,
    output logic                    mul_z_ack,
    output logic                    busy,
    output logic [OP_COUNT_W-1:0]   op_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arbState_t               r_state;
    arbState_t               w_nextState;
    logic [IDX_W-1:0]        r_lastGrant;
    logic [IDX_W-1:0]        r_idx;
    logic [FP_W-1:0]         r_opA;
    logic [FP_W-1:0]         r_opB;
    logic [FP_W-1:0]         r_rspZ;
    logic                    r_mulZAck;
    logic [OP_COUNT_W-1:0]   r_opCount;

    logic [NUM_REQ-1:0]      w_grant;
    logic [IDX_W-1:0]        w_grantIdx;
    logic                    w_anyReq;
    logic [NUM_REQ-1:0]      w_idxOneHot;
    logic                    w_accept;
    logic                    w_complete;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rrArbiter (
        .i_req       (req_valid),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_grant),
        .o_grantIdx  (w_grantIdx),
        .o_anyReq    (w_anyReq)
    );

    assign w_idxOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;
    assign w_accept    = (r_state == IDLE) && w_anyReq;
    assign w_complete  = (r_state == RESPOND) && rsp_ready[r_idx];

    // State register; reset abandons any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: each handshake phase advances only on its own acknowledge.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq)         w_nextState = SEND_A;
            SEND_A:  if (mul_a_ack)        w_nextState = SEND_B;
            SEND_B:  if (mul_b_ack)        w_nextState = WAIT_Z;
            WAIT_Z:  if (mul_z_req)        w_nextState = RESPOND;
            RESPOND: if (rsp_ready[r_idx]) w_nextState = IDLE;
            default:                       w_nextState = IDLE;
        endcase
    end

    // Datapath: latch the winner's operands, capture the product, and record
    // the completed grant so the next search starts after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastGrant <= IDX_W'(NUM_REQ - 1);
            r_idx       <= '0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_rspZ      <= '0;
            r_mulZAck   <= 1'b0;
            r_opCount   <= '0;
        end else begin
            r_mulZAck <= 1'b0;
            if (w_accept) begin
                r_idx <= w_grantIdx;
                r_opA <= req_a[int'(w_grantIdx)*FP_W +: FP_W];
                r_opB <= req_b[int'(w_grantIdx)*FP_W +: FP_W];
            end
            if ((r_state == WAIT_Z) && mul_z_req) begin
                r_rspZ    <= mul_z;
                r_mulZAck <= 1'b1;
            end
            if (w_complete) begin
                r_lastGrant <= r_idx;
                r_opCount   <= r_opCount + OP_COUNT_W'(1);
            end
        end
    end

    // State-decoded handshake strobes; the acceptance pulse is suppressed
    // while reset is held so nothing appears accepted during reset.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        mul_a_req = 1'b0;
        mul_b_req = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (!rst) begin
                    req_ready = w_grant;
                end
            end
            SEND_A:  mul_a_req = 1'b1;
            SEND_B:  mul_b_req = 1'b1;
            WAIT_Z:  ;
            RESPOND: rsp_valid = w_idxOneHot;
            default: ;
        endcase
    end

    assign mul_a     = r_opA;
    assign mul_b     = r_opB;
    assign rsp_z     = r_rspZ;
    assign mul_z_ack = r_mulZAck;
    assign op_count  = r_opCount;

endmodule
